parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//  Sequences the single shared barrier gate of the car park between an entry lane and an exit lane.
//  Arbitrates lane requests, opens the gate for one vehicle, and waits for the pass sensor or a timeout.
//  Issues one-cycle car_enter / car_exit pulses to the occupancy counter. Refuses entry when occupancy is full.
//  Sits between the lane sensors/barrier driver and the occupancy counter, which feeds occupancy back.
// PARAMETERS
//  CNT_W           8     width of occupancy input
//  CAPACITY        255   occupancy at which entry is refused (<= 2**CNT_W-1)
//  TIMEOUT_CYCLES  1000  max cycles the gate stays open waiting for pass_sense
//  CLOSE_CYCLES    4     hold-off cycles with gate closed before the next grant
//  TMR_W           16    timer width; must satisfy 2**TMR_W > max(TIMEOUT_CYCLES, CLOSE_CYCLES)
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  reset       in   1      asynchronous, active-high reset
//  req_in      in   1      entry-lane vehicle present (level, held until grant_in or withdrawn)
//  req_out     in   1      exit-lane vehicle present (level)
//  pass_sense  in   1      vehicle has cleared the barrier (level; sampled only while serving)
//  occupancy   in   CNT_W  current car count from occupancy counter
//  grant_in    out  1      gate currently serving entry lane
//  grant_out   out  1      gate currently serving exit lane
//  gate_open   out  1      barrier open command (= grant_in | grant_out)
//  car_enter   out  1      1-cycle pulse: entry completed, counter +1
//  car_exit    out  1      1-cycle pulse: exit completed, counter -1
//  full        out  1      registered: occupancy >= CAPACITY
//  timeout     out  1      1-cycle pulse: service aborted, no vehicle passed
// BEHAVIOUR
//  Reset: state=IDLE, timer=0, prio=EXIT, every output 0. Asserting reset mid-service drops gate_open immediately.
//  All outputs registered. Eligibility: in_ok = req_in & (occupancy < CAPACITY); out_ok = req_out & (occupancy != 0).
//  IDLE: if in_ok & out_ok, grant to lane named by prio; else grant the single eligible lane; else stay.
//    Granting loads timer=0 and flips prio to the other lane. grant_* and gate_open rise 1 cycle after the
//    req is sampled.
//  SERVE_IN / SERVE_OUT: gate_open=1, timer increments each cycle.
//    pass_sense=1 -> next cycle: car_enter (or car_exit)=1 for exactly one cycle, grant low; go CLOSING.
//    else timer == TIMEOUT_CYCLES-1 -> next cycle: timeout=1 for one cycle, no count pulse; go CLOSING.
//    pass_sense wins if both occur in the same cycle. Req deassertion during service is ignored.
//  CLOSING: gate_open=0, timer counts 0..CLOSE_CYCLES-1, then IDLE. Requests are not sampled here.
//  full is recomputed every cycle from occupancy; entry is never granted while full=1, even with no exit req.
//  Exit is never granted at occupancy==0. At most one of car_enter/car_exit/timeout is high per cycle.
//  occupancy changes during service do not abort service.
//  Illegal state encodings recover to IDLE with outputs 0.
// STRUCTURE
//  parking_pkg: typedef enum {IDLE, SERVE_IN, SERVE_OUT, CLOSING} gate_state_t; lane_t {LANE_IN, LANE_OUT}.
//  Sub-module parking_hold_timer (clear, enable, terminal value in, expired out), instanced once.
//  It is shared by the SERVE and CLOSING states, with the terminal value muxed by state.
// TESTING
//  1 reset mid-SERVE_IN (cycle 3 of service) -> gate_open=0 same cycle; after release: IDLE, prio=EXIT, no pulses.
//  2 occupancy=10, req_in=1, pass_sense at service cycle 5 -> grant_in 1 cycle after req; one car_enter pulse;
//    gate_open low for exactly 4 cycles before the next grant.
//  3 occupancy=10, req_in=req_out=1 held for 3 services -> grant order OUT, IN, OUT; exactly one pulse per service.
//  4 occupancy=255 (CAPACITY), req_in=1 only -> full=1, no grant for 50 cycles; then req_out=1 -> grant_out, car_exit.
//  5 occupancy=0, req_out=1 -> no grant, no car_exit; req_in=1 -> grant_in normally.
//  6 occupancy=5, req_in=1, pass_sense never -> gate_open high exactly 1000 cycles; one timeout pulse; no car_enter.

Source files
------------

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types for the parking gate arbiter
package parking_pkg;

  // Gate sequencer states; the 2-bit encoding is fully used.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IN  = 2'd1,
    SERVE_OUT = 2'd2,
    CLOSING   = 2'd3
  } gate_state_t;

  // Lane identifier, also used as the round-robin priority token.
  typedef enum logic {
    LANE_IN  = 1'b0,
    LANE_OUT = 1'b1
  } lane_t;

  // The lane that gets priority after the given lane has been served.
  function automatic lane_t other_lane(input lane_t served);
    return (served == LANE_IN) ? LANE_OUT : LANE_IN;
  endfunction

endpackage

// File: rtl/parking_hold_timer.sv
// rtl/parking_hold_timer.sv - cycle counter with clear, enable and terminal compare
module parking_hold_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMR_W-1:0] terminal,
  output logic             expired
);

  localparam logic [TMR_W-1:0] ONE = TMR_W'(1);

  logic [TMR_W-1:0] count;

  // Count up while enabled; clear has priority so a state change restarts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

  // Expired is asserted during the cycle whose count equals the terminal value.
  assign expired = (count == terminal);

endmodule

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - shared barrier sequencer for entry and exit lanes
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int CAPACITY       = 255,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CLOSE_CYCLES   = 4,
  parameter int TMR_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             pass_sense,
  input  logic [CNT_W-1:0] occupancy,
  output logic             grant_in,
  output logic             grant_out,
  output logic             gate_open,
  output logic             car_enter,
  output logic             car_exit,
  output logic             full,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CAP        = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] SERVE_TERM = TMR_W'(TIMEOUT_CYCLES - 1);
  // The IDLE arbitration cycle is the last closed cycle of the hold-off, so
  // CLOSING itself lasts one cycle less than the full hold-off.
  localparam logic [TMR_W-1:0] CLOSE_TERM =
    TMR_W'((CLOSE_CYCLES > 1) ? (CLOSE_CYCLES - 2) : 0);

  gate_state_t      state, state_n;
  lane_t            prio, prio_n;
  logic             grant_in_n, grant_out_n;
  logic             car_enter_n, car_exit_n, timeout_n;
  logic             full_n;
  logic             in_ok, out_ok;
  logic             tmr_clear, tmr_enable, tmr_expired;
  logic [TMR_W-1:0] tmr_term;

  // Entry also checks the registered full flag so a grant never coincides with full=1.
  assign in_ok  = req_in  & (occupancy < CAP) & ~full;
  assign out_ok = req_out & (occupancy != '0);
  assign full_n = (occupancy >= CAP);

  parking_hold_timer #(
    .TMR_W (TMR_W)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .terminal (tmr_term),
    .expired  (tmr_expired)
  );

  // State, priority token and all outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= LANE_OUT;
      grant_in  <= 1'b0;
      grant_out <= 1'b0;
      gate_open <= 1'b0;
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
      full      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      prio      <= prio_n;
      grant_in  <= grant_in_n;
      grant_out <= grant_out_n;
      gate_open <= grant_in_n | grant_out_n;
      car_enter <= car_enter_n;
      car_exit  <= car_exit_n;
      full      <= full_n;
      timeout   <= timeout_n;
    end
  end

  // Next-state, next-output and hold-timer control.
  always_comb begin
    state_n     = state;
    prio_n      = prio;
    grant_in_n  = 1'b0;
    grant_out_n = 1'b0;
    car_enter_n = 1'b0;
    car_exit_n  = 1'b0;
    timeout_n   = 1'b0;
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;
    tmr_term    = SERVE_TERM;

    case (state)
      IDLE: begin
        tmr_clear = 1'b1;
        if (in_ok && (!out_ok || prio == LANE_IN)) begin
          state_n    = SERVE_IN;
          grant_in_n = 1'b1;
          prio_n     = other_lane(LANE_IN);
        end else if (out_ok) begin
          state_n     = SERVE_OUT;
          grant_out_n = 1'b1;
          prio_n      = other_lane(LANE_OUT);
        end
      end

      SERVE_IN, SERVE_OUT: begin
        tmr_term = SERVE_TERM;
        if (pass_sense) begin
          state_n     = CLOSING;
          tmr_clear   = 1'b1;
          car_enter_n = (state == SERVE_IN);
          car_exit_n  = (state == SERVE_OUT);
        end else if (tmr_expired) begin
          state_n   = CLOSING;
          tmr_clear = 1'b1;
          timeout_n = 1'b1;
        end else begin
          tmr_enable  = 1'b1;
          grant_in_n  = (state == SERVE_IN);
          grant_out_n = (state == SERVE_OUT);
        end
      end

      CLOSING: begin
        tmr_term = CLOSE_TERM;
        if (tmr_expired) begin
          state_n   = IDLE;
          tmr_clear = 1'b1;
        end else begin
          tmr_enable = 1'b1;
        end
      end

      default: begin
        state_n   = IDLE;
        tmr_clear = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed vector bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

  logic       clk;
  logic       reset;
  logic       req_in, req_out, pass_sense;
  logic [7:0] occupancy;
  logic       grant_in, grant_out, gate_open, car_enter, car_exit, full, timeout;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct {
    logic       ri, ro, ps;
    logic [7:0] occ;
    logic [6:0] exp;   // {grant_in, grant_out, gate_open, car_enter, car_exit, full, timeout}
  } vec_t;

  vec_t tbl[$];

  parking_gate_arbiter #(
    .CNT_W(8), .CAPACITY(255), .TIMEOUT_CYCLES(1000), .CLOSE_CYCLES(4), .TMR_W(16)
  ) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .req_out(req_out),
    .pass_sense(pass_sense), .occupancy(occupancy), .grant_in(grant_in),
    .grant_out(grant_out), .gate_open(gate_open), .car_enter(car_enter),
    .car_exit(car_exit), .full(full), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {grant_in, grant_out, gate_open, car_enter, car_exit, full, timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic ri, input logic ro, input logic ps, input logic [7:0] occ,
                     input logic [6:0] exp);
    vec_t v;
    v.ri = ri; v.ro = ro; v.ps = ps; v.occ = occ; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Advance one clock and sample 1 time unit after the edge; check invariants.
  task automatic step();
    @(posedge clk);
    #1;
    check("gate_open_eq_grants", 32'(gate_open), 32'(grant_in | grant_out));
    check("pulse_onehot", 32'(32'(car_enter) + 32'(car_exit) + 32'(timeout) <= 1), 32'd1);
  endtask

  initial begin
    int go_cnt, to_cnt, ce_cnt;
    reset = 1'b1; req_in = 1'b0; req_out = 1'b0; pass_sense = 1'b0; occupancy = 8'd10;

    step();
    check("reset_state", 32'(outs()), 32'b0000000);
    reset = 1'b0;

    // Reset during service cycle 3 drops the gate at once; afterwards prio is EXIT.
    req_in = 1'b1;
    step();
    check("sc1_grant", 32'(outs()), 32'b1010000);
    step();
    step();
    reset = 1'b1;
    #1;
    check("sc1_async_drop", 32'(outs()), 32'b0000000);
    step();
    reset = 1'b0;
    req_in = 1'b0;
    step();
    check("sc1_idle_after", 32'(outs()), 32'b0000000);
    req_in = 1'b1; req_out = 1'b1;
    step();
    check("sc1_prio_exit", 32'(outs()), 32'b0110000);
    reset = 1'b1;
    step();
    reset = 1'b0; req_in = 1'b0; req_out = 1'b0;

    // Single entry with pass at service cycle 5, closing hold-off, then alternating service.
    add(1,0,0,10, 7'b1010000);
    add(1,0,0,10, 7'b1010000);
    add(1,0,0,10, 7'b1010000);
    add(0,0,0,10, 7'b1010000);
    add(0,0,0,10, 7'b1010000);
    add(1,0,1,10, 7'b0001000);
    add(1,0,0,10, 7'b0000000);
    add(1,0,0,10, 7'b0000000);
    add(1,0,0,10, 7'b0000000);
    add(1,0,0,10, 7'b1010000);
    add(0,0,1,10, 7'b0001000);
    add(0,0,0,10, 7'b0000000);
    add(0,0,0,10, 7'b0000000);
    add(0,0,0,10, 7'b0000000);
    add(0,0,0,10, 7'b0000000);
    add(1,1,0,10, 7'b0110000);
    add(1,1,1,10, 7'b0000100);
    add(1,1,0,10, 7'b0000000);
    add(1,1,0,10, 7'b0000000);
    add(1,1,0,10, 7'b0000000);
    add(1,1,0,10, 7'b1010000);
    add(1,1,1,10, 7'b0001000);
    add(1,1,0,10, 7'b0000000);
    add(1,1,0,10, 7'b0000000);
    add(1,1,0,10, 7'b0000000);
    add(1,1,0,10, 7'b0110000);
    add(0,0,1,10, 7'b0000100);
    add(0,0,0,10, 7'b0000000);
    add(0,0,0,10, 7'b0000000);
    add(0,0,0,10, 7'b0000000);
    add(0,0,0,10, 7'b0000000);

    for (int i = 0; i < tbl.size(); i++) begin
      req_in = tbl[i].ri; req_out = tbl[i].ro; pass_sense = tbl[i].ps; occupancy = tbl[i].occ;
      step();
      check($sformatf("row_%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    pass_sense = 1'b0;

    // Full car park: entry refused for 50 cycles, exit still served.
    occupancy = 8'd255; req_in = 1'b1; req_out = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      check($sformatf("sc4_refuse_%0d", i), 32'({grant_in, grant_out, full}), 32'b001);
    end
    req_out = 1'b1;
    step();
    check("sc4_grant_out", 32'({grant_in, grant_out, gate_open, full}), 32'b0111);
    req_in = 1'b0; req_out = 1'b0; pass_sense = 1'b1;
    step();
    check("sc4_car_exit", 32'(outs()), 32'b0000110);
    pass_sense = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Empty car park: exit refused, entry granted.
    occupancy = 8'd0; req_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("sc5_refuse_%0d", i), 32'({grant_in, grant_out, car_exit}), 32'b000);
    end
    req_in = 1'b1;
    step();
    check("sc5_grant_in", 32'(outs()), 32'b1010000);
    req_in = 1'b0; req_out = 1'b0; pass_sense = 1'b1;
    step();
    check("sc5_car_enter", 32'(outs()), 32'b0001000);
    pass_sense = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Timeout: gate open exactly 1000 cycles, one timeout pulse, no count pulse.
    occupancy = 8'd5; req_in = 1'b1;
    go_cnt = 0; to_cnt = 0; ce_cnt = 0;
    for (int i = 0; i < 1010; i++) begin
      step();
      if (grant_in) req_in = 1'b0;
      go_cnt += int'(gate_open);
      to_cnt += int'(timeout);
      ce_cnt += int'(car_enter);
    end
    check("sc6_open_cycles", 32'(go_cnt), 32'd1000);
    check("sc6_timeout_pulses", 32'(to_cnt), 32'd1);
    check("sc6_no_car_enter", 32'(ce_cnt), 32'd0);
    check("sc6_final_idle", 32'(outs()), 32'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
